line_cmd_builder: RTL and testbench

LINE_CMD_BUILDER -- requirements
Module: line_cmd_builder

---
 rtl/line_draw_pkg.sv | 12 +
 rtl/coord_clamp.sv | 13 +
 rtl/line_cmd_builder.sv | 94 +++++++++
 tb/tb_line_cmd_builder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_draw_pkg.sv
// line_draw_pkg: state encoding and default screen geometry for the line command path.
package line_draw_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_PEND  = 2'd2,
        ST_ISSUE = 2'd3
    } line_state_t;
    localparam int LD_SCREEN_W = 640;
    localparam int LD_SCREEN_H = 480;
    localparam int LD_COORD_W  = 11;
endpackage

// File: rtl/coord_clamp.sv
// coord_clamp: saturates one coordinate to P_MAX and flags when saturation happened.
module coord_clamp #(
    parameter int P_W   = 11,
    parameter int P_MAX = 639
) (
    input  logic [P_W-1:0] i_coord,
    output logic [P_W-1:0] o_coord,
    output logic           o_clamped
);
    localparam logic [P_W-1:0] LIM = P_W'(P_MAX);
    assign o_clamped = i_coord > LIM;
    assign o_coord   = o_clamped ? LIM : i_coord;
endmodule

// File: rtl/line_cmd_builder.sv
// line_cmd_builder: gathers two captured points into a line segment and issues it to the line FIFO.
// Define LINE_CMD_POLYLINE_EN to chain segments: each end point becomes the next start point.
module line_cmd_builder
    import line_draw_pkg::*;
#(
    parameter int P_X_COORD_W = LD_COORD_W,
    parameter int P_Y_COORD_W = LD_COORD_W,
    parameter int P_SCREEN_W  = LD_SCREEN_W,
    parameter int P_SCREEN_H  = LD_SCREEN_H
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [P_X_COORD_W-1:0] i_coord_x,
    input  logic [P_Y_COORD_W-1:0] i_coord_y,
    input  logic                   i_capture,
    input  logic                   i_cancel,
    input  logic                   i_fifo_full,
    output logic [P_X_COORD_W-1:0] o_x0,
    output logic [P_Y_COORD_W-1:0] o_y0,
    output logic [P_X_COORD_W-1:0] o_x1,
    output logic [P_Y_COORD_W-1:0] o_y1,
    output logic                   o_load,
    output logic [1:0]             o_state,
    output logic [7:0]             o_seg_count,
    output logic                   o_clamped
);
    line_state_t state, state_nxt;
    logic [P_X_COORD_W-1:0] cx;
    logic [P_Y_COORD_W-1:0] cy;
    logic clx, cly, take;

    coord_clamp #(.P_W(P_X_COORD_W), .P_MAX(P_SCREEN_W-1)) u_clamp_x (
        .i_coord(i_coord_x), .o_coord(cx), .o_clamped(clx)
    );
    coord_clamp #(.P_W(P_Y_COORD_W), .P_MAX(P_SCREEN_H-1)) u_clamp_y (
        .i_coord(i_coord_y), .o_coord(cy), .o_clamped(cly)
    );

    // A capture is only accepted while a point is still missing, and cancel always overrides it.
    assign take    = i_capture && !i_cancel && (state == ST_IDLE || state == ST_START);
    assign o_state = state;

    always_comb begin
        state_nxt = state;
        o_load    = 1'b0;
        unique case (state)
            ST_IDLE:  state_nxt = take ? ST_START : ST_IDLE;
            ST_START: state_nxt = i_cancel ? ST_IDLE : take ? ST_PEND : ST_START;
            ST_PEND:  state_nxt = i_cancel ? ST_IDLE : i_fifo_full ? ST_PEND : ST_ISSUE;
            ST_ISSUE: begin
                o_load = 1'b1;
`ifdef LINE_CMD_POLYLINE_EN
                state_nxt = ST_START;
`else
                state_nxt = ST_IDLE;
`endif
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            o_x0        <= '0;
            o_y0        <= '0;
            o_x1        <= '0;
            o_y1        <= '0;
            o_seg_count <= '0;
            o_clamped   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take && state == ST_IDLE) begin
                o_x0 <= cx;
                o_y0 <= cy;
            end
            if (take && state == ST_START) begin
                o_x1 <= cx;
                o_y1 <= cy;
            end
            if (take && (clx || cly))
                o_clamped <= 1'b1;
            // Counting on entry makes the new count visible alongside o_load.
            if (state == ST_PEND && state_nxt == ST_ISSUE)
                o_seg_count <= o_seg_count + 8'd1;
`ifdef LINE_CMD_POLYLINE_EN
            if (state == ST_ISSUE) begin
                o_x0 <= o_x1;
                o_y0 <= o_y1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_line_cmd_builder.sv
// tb_line_cmd_builder: directed checks of the line command builder, expectations follow LINE_CMD_POLYLINE_EN.
module tb_line_cmd_builder;
`ifdef LINE_CMD_POLYLINE_EN
    localparam bit POLY = 1'b1;
`else
    localparam bit POLY = 1'b0;
`endif
    logic        i_clk = 1'b0, i_reset = 1'b1, i_capture = 1'b0, i_cancel = 1'b0, i_fifo_full = 1'b0;
    logic [10:0] i_coord_x = '0, i_coord_y = '0;
    logic [10:0] o_x0, o_y0, o_x1, o_y1;
    logic        o_load, o_clamped;
    logic [1:0]  o_state;
    logic [7:0]  o_seg_count;
    int checks = 0, errors = 0, n;

    line_cmd_builder dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_coord_x(i_coord_x), .i_coord_y(i_coord_y),
        .i_capture(i_capture), .i_cancel(i_cancel), .i_fifo_full(i_fifo_full),
        .o_x0(o_x0), .o_y0(o_y0), .o_x1(o_x1), .o_y1(o_y1), .o_load(o_load),
        .o_state(o_state), .o_seg_count(o_seg_count), .o_clamped(o_clamped)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, 32'(o_state), 0);
        chk({tag, "_x0"}, 32'(o_x0), 0);
        chk({tag, "_y0"}, 32'(o_y0), 0);
        chk({tag, "_x1"}, 32'(o_x1), 0);
        chk({tag, "_y1"}, 32'(o_y1), 0);
        chk({tag, "_load"}, 32'(o_load), 0);
        chk({tag, "_count"}, 32'(o_seg_count), 0);
        chk({tag, "_clamped"}, 32'(o_clamped), 0);
    endtask

    task automatic cap(input int x, input int y);
        i_coord_x = 11'(x);
        i_coord_y = 11'(y);
        i_capture = 1'b1;
        tick();
        i_capture = 1'b0;
    endtask

    task automatic cancel();
        i_cancel = 1'b1;
        tick();
        i_cancel = 1'b0;
    endtask

    task automatic quiet(input string tag, input int cycles);
        n = 0;
        repeat (cycles) begin
            tick();
            if (o_load) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        tick();
        tick();
        chk_zero("reset");
        i_reset = 1'b0;
        tick();
        chk("idle_hold", 32'(o_state), 0);
        // basic segment and latency
        cap(10, 20);
        chk("s1_state", 32'(o_state), 1);
        chk("s1_x0", 32'(o_x0), 10);
        chk("s1_y0", 32'(o_y0), 20);
        cap(100, 200);
        chk("s1_pend", 32'(o_state), 2);
        chk("s1_noload", 32'(o_load), 0);
        chk("s1_x1", 32'(o_x1), 100);
        chk("s1_y1", 32'(o_y1), 200);
        tick();
        chk("s1_load", 32'(o_load), 1);
        chk("s1_issue", 32'(o_state), 3);
        chk("s1_ex0", 32'(o_x0), 10);
        chk("s1_ey0", 32'(o_y0), 20);
        chk("s1_count", 32'(o_seg_count), 1);
        tick();
        chk("s1_load_end", 32'(o_load), 0);
        chk("s1_exit", 32'(o_state), POLY ? 1 : 0);
        chk("s1_x0_after", 32'(o_x0), POLY ? 100 : 10);
        chk("s1_unclamped", 32'(o_clamped), 0);
        cancel();
        chk("s1_idle", 32'(o_state), 0);
        // edge of screen is not clamped
        cap(639, 479);
        chk("edge_x0", 32'(o_x0), 639);
        chk("edge_y0", 32'(o_y0), 479);
        chk("edge_noclamp", 32'(o_clamped), 0);
        cancel();
        chk("cancel_state", 32'(o_state), 0);
        chk("cancel_load", 32'(o_load), 0);
        chk("cancel_keep_x0", 32'(o_x0), 639);
        cap(700, 500);
        chk("clamp_x0", 32'(o_x0), 639);
        chk("clamp_y0", 32'(o_y0), 479);
        chk("clamp_flag", 32'(o_clamped), 1);
        chk("clamp_state", 32'(o_state), 1);
        cancel();
        // capture+cancel together
        i_coord_x = 11'd5;
        i_coord_y = 11'd5;
        i_capture = 1'b1;
        i_cancel = 1'b1;
        tick();
        i_capture = 1'b0;
        i_cancel = 1'b0;
        chk("both_idle_state", 32'(o_state), 0);
        chk("both_idle_x0", 32'(o_x0), 639);
        cap(1, 2);
        i_coord_x = 11'd3;
        i_coord_y = 11'd4;
        i_capture = 1'b1;
        i_cancel = 1'b1;
        tick();
        i_capture = 1'b0;
        i_cancel = 1'b0;
        chk("both_start_state", 32'(o_state), 0);
        chk("both_start_x1", 32'(o_x1), 100);
        quiet("both_noload", 3);
        // back-pressure
        i_fifo_full = 1'b1;
        cap(5, 6);
        cap(7, 8);
        cap(50, 51);
        chk("pend_cap_x1", 32'(o_x1), 7);
        chk("pend_cap_y1", 32'(o_y1), 8);
        chk("pend_cap_x0", 32'(o_x0), 5);
        for (int i = 0; i < 50; i++) begin
            chk("full_state", 32'(o_state), 2);
            chk("full_noload", 32'(o_load), 0);
            tick();
        end
        i_fifo_full = 1'b0;
        tick();
        chk("full_load", 32'(o_load), 1);
        chk("full_count", 32'(o_seg_count), 2);
        chk("full_ey1", 32'(o_y1), 8);
        quiet("full_single", 4);
        cancel();
        // cancel while pending
        i_fifo_full = 1'b1;
        cap(9, 9);
        cap(11, 11);
        cancel();
        chk("pcancel_state", 32'(o_state), 0);
        i_fifo_full = 1'b0;
        quiet("pcancel_noload", 3);
        chk("pcancel_count", 32'(o_seg_count), 2);
        chk("pcancel_x1", 32'(o_x1), 11);
        // cancel and capture during issue are ignored
        cap(12, 13);
        cap(14, 15);
        tick();
        chk("icancel_issue", 32'(o_state), 3);
        i_coord_x = 11'd60;
        i_coord_y = 11'd61;
        i_capture = 1'b1;
        i_cancel = 1'b1;
        tick();
        i_capture = 1'b0;
        i_cancel = 1'b0;
        chk("icancel_count", 32'(o_seg_count), 3);
        chk("icancel_exit", 32'(o_state), POLY ? 1 : 0);
        chk("icancel_x0", 32'(o_x0), POLY ? 14 : 12);
        chk("icancel_x1", 32'(o_x1), 14);
        chk("icancel_load", 32'(o_load), 0);
        cancel();
        // three points
        cap(1, 1);
        cap(2, 2);
        tick();
        chk("tri_load1", 32'(o_load), 1);
        chk("tri_x0", 32'(o_x0), 1);
        chk("tri_x1", 32'(o_x1), 2);
        tick();
        chk("tri_mid_state", 32'(o_state), POLY ? 1 : 0);
        chk("tri_mid_x0", 32'(o_x0), POLY ? 2 : 1);
        cap(3, 3);
        chk("tri_p2_state", 32'(o_state), POLY ? 2 : 1);
        chk("tri_p2_x0", 32'(o_x0), POLY ? 2 : 3);
        tick();
        chk("tri_load2", 32'(o_load), POLY ? 1 : 0);
        chk("tri_seg2_x0", 32'(o_x0), POLY ? 2 : 3);
        chk("tri_seg2_x1", 32'(o_x1), POLY ? 3 : 2);
        chk("tri_count", 32'(o_seg_count), POLY ? 5 : 4);
        tick();
        cancel();
        chk("tri_idle", 32'(o_state), 0);
        // reset in PEND
        i_fifo_full = 1'b1;
        cap(20, 21);
        cap(22, 23);
        chk("rpend_state", 32'(o_state), 2);
        i_reset = 1'b1;
        #1;
        chk_zero("rst_pend");
        i_fifo_full = 1'b0;
        tick();
        i_reset = 1'b0;
        quiet("rpend_noload", 4);
        chk("rpend_idle", 32'(o_state), 0);
        // reset in ISSUE
        cap(24, 25);
        cap(26, 27);
        tick();
        chk("rissue_load", 32'(o_load), 1);
        i_reset = 1'b1;
        #1;
        chk_zero("rst_issue");
        tick();
        i_reset = 1'b0;
        quiet("rissue_noload", 4);
        // counter wrap
        for (int i = 0; i < 256; i++) begin
            cap(i, 1);
            cap(2, 3);
            tick();
            chk("wrap_load", 32'(o_load), 1);
            if (i == 254) chk("wrap_255", 32'(o_seg_count), 255);
            tick();
            chk("wrap_no_double", 32'(o_load), 0);
            cancel();
        end
        chk("wrap_zero", 32'(o_seg_count), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
